vga_timing_gen: RTL and testbench

Pixel-timing master for the 640x480@60 Hz display path. It runs the horizontal and vertical counters on the 25 MHz pixel clock and publishes the next pixel's coordinates (`next_x`, `next_y`) to the game renderer. It samples the renderer's colour (`R_in`/`G_in`/`B_in`) one cycle later and drives the registered VGA DAC pins with syncs aligned to that colour. It also emits a once-per-frame tick and a frame counter, which the pattern and scroll logic uses as its time base.

---
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 pixel-timing master with registered DAC outputs,
// one-cycle colour latency, and a per-frame tick/counter for game logic.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        CLOCK_25,
    input  logic        rst,
    input  logic [7:0]  R_in,
    input  logic [7:0]  G_in,
    input  logic [7:0]  B_in,
    output logic [9:0]  next_x,
    output logic [9:0]  next_y,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_tick,
    output logic [15:0] frame_count
);
    localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0] H_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0]  hc_q, hc_d, vc_q, vc_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic        hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d, tick_q, tick_d;
    logic [15:0] count_q, count_d;
    logic        h_end, v_end, visible;

    // Output stage is decoded from the current counters, so pins lag next_x/next_y by one cycle.
    always_comb begin
        h_end     = hc_q == H_LAST;
        v_end     = vc_q == V_LAST;
        visible   = (hc_q < H_VIS) && (vc_q < V_VIS);
        hc_d      = h_end ? 10'd0 : hc_q + 10'd1;
        vc_d      = !h_end ? vc_q : (v_end ? 10'd0 : vc_q + 10'd1);
        r_d       = visible ? R_in : 8'd0;
        g_d       = visible ? G_in : 8'd0;
        b_d       = visible ? B_in : 8'd0;
        blank_n_d = visible;
        hs_d      = !((hc_q >= HS_FIRST) && (hc_q <= HS_LAST));
        vs_d      = !((vc_q >= VS_FIRST) && (vc_q <= VS_LAST));
        tick_d    = (hc_q == H_VIS - 10'd1) && (vc_q == V_VIS - 10'd1);
        count_d   = count_q + 16'(tick_d);
    end

    always_ff @(posedge CLOCK_25 or posedge rst) begin
        if (rst) begin
            hc_q      <= '0;
            vc_q      <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            tick_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            tick_q    <= tick_d;
            count_q   <= count_d;
        end
    end

    assign next_x      = hc_q;
    assign next_y      = vc_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_CLK     = ~CLOCK_25;
    assign frame_tick  = tick_q;
    assign frame_count = count_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of line timing on a full-size instance and
// frame timing/tick/count on a reduced-geometry instance (15x9 totals).
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst_a, rst_b, mode_ff;
    logic [7:0] r_in, g_in, b_in;

    logic [9:0]  x_a, y_a, x_b, y_b;
    logic [7:0]  ra, ga, ba, rb, gb, bb;
    logic        hs_a, vs_a, bn_a, sn_a, vclk_a, tick_a;
    logic        hs_b, vs_b, bn_b, sn_b, vclk_b, tick_b;
    logic [15:0] fc_a, fc_b;

    assign r_in = mode_ff ? 8'hFF : ((x_a == 10'd5 && y_a == 10'd3) ? 8'hFF : 8'h00);
    assign g_in = mode_ff ? 8'hFF : 8'h00;
    assign b_in = mode_ff ? 8'hFF : 8'h00;

    vga_timing_gen dut (
        .CLOCK_25(clk), .rst(rst_a), .R_in(r_in), .G_in(g_in), .B_in(b_in),
        .next_x(x_a), .next_y(y_a), .VGA_R(ra), .VGA_G(ga), .VGA_B(ba),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bn_a), .VGA_SYNC_N(sn_a),
        .VGA_CLK(vclk_a), .frame_tick(tick_a), .frame_count(fc_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) dut_s (
        .CLOCK_25(clk), .rst(rst_b), .R_in(r_in), .G_in(g_in), .B_in(b_in),
        .next_x(x_b), .next_y(y_b), .VGA_R(rb), .VGA_G(gb), .VGA_B(bb),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bn_b), .VGA_SYNC_N(sn_b),
        .VGA_CLK(vclk_b), .frame_tick(tick_b), .frame_count(fc_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int hits, hx, hy, hb;
    int t0, t1, t2, hs_low, g_high, viol;
    int ticks, wide, vs_low, vs_first, wraps, wrap_bad, ybad, got;
    int tick_t [1:3];
    int tick_x [1:3];
    int tick_y [1:3];
    int tick_fc[1:3];
    logic prev_tick;
    logic [9:0] px, py;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; mode_ff = 1'b0;
        step(); step();
        chk("reset_r", ra, 0);
        chk("reset_hs", hs_a, 1);
        chk("reset_vs", vs_a, 1);
        chk("reset_blank_n", bn_a, 0);
        chk("reset_frame_count", fc_a, 0);
        chk("reset_x", x_a, 0);
        chk("reset_y", y_a, 0);
        chk("sync_n", sn_a, 1);
        chk("vga_clk_inverted", vclk_a, 0);
        @(negedge clk); rst_a = 1'b0; rst_b = 1'b0;
        step();
        chk("x_after_release", x_a, 1);
        chk("blank_n_pixel0", bn_a, 1);
        step();
        chk("x_increments", x_a, 2);
        repeat (298) step();
        chk("x_at_300", x_a, 300);
        #5 rst_a = 1'b1;
        #1;
        chk("async_blank_n", bn_a, 0);
        chk("async_x", x_a, 0);
        chk("async_hs", hs_a, 1);
        chk("async_vs", vs_a, 1);
        chk("async_frame_count", fc_a, 0);
        @(negedge clk); rst_a = 1'b0;

        // colour latency: (5,3) lit only, seen on pins while counters sit at (6,3)
        hits = 0; hx = -1; hy = -1; hb = -1;
        for (int i = 1; i <= 3200; i++) begin
            step();
            if (ra == 8'hFF) begin hits++; hx = x_a; hy = y_a; hb = bn_a; end
        end
        chk("latency_hits", hits, 1);
        chk("latency_x", hx, 6);
        chk("latency_y", hy, 3);
        chk("latency_blank_n", hb, 1);

        // two visible lines with constant white input
        mode_ff = 1'b1;
        t0 = -1; t1 = -1; t2 = -1; hs_low = 0; g_high = 0; viol = 0;
        for (int i = 1; i <= 1600; i++) begin
            step();
            if (x_a == 10'd1) begin
                if (t0 < 0) t0 = i; else if (t2 < 0) t2 = i;
            end
            if (!hs_a && t1 < 0) t1 = i;
            if (!hs_a && i <= 800) hs_low++;
            if (ga == 8'hFF) g_high++;
            if (!bn_a && (ra != 0 || ga != 0 || ba != 0)) viol++;
        end
        chk("hs_start_offset", t1 - t0, 656);
        chk("hs_low_cycles", hs_low, 96);
        chk("line_period", t2 - t0, 800);
        chk("visible_high_2lines", g_high, 1280);
        chk("blank_colour_a", viol, 0);

        // reduced instance: 3 frames of 135 cycles
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk); rst_b = 1'b0;
        ticks = 0; wide = 0; vs_low = 0; vs_first = -1; g_high = 0; viol = 0;
        wraps = 0; wrap_bad = 0; ybad = 0; prev_tick = 1'b0; px = 10'd0; py = 10'd0;
        for (int t = 1; t <= 405; t++) begin
            step();
            if (tick_b) begin
                ticks++;
                if (ticks <= 3) begin
                    tick_t[ticks] = t; tick_x[ticks] = x_b;
                    tick_y[ticks] = y_b; tick_fc[ticks] = fc_b;
                end
                if (prev_tick) wide++;
            end
            if (!vs_b) begin vs_low++; if (vs_first < 0) vs_first = t; end
            if (gb == 8'hFF) g_high++;
            if (!bn_b && (rb != 0 || gb != 0 || bb != 0)) viol++;
            if (px == 10'd14 && py == 10'd8) begin
                wraps++;
                if (x_b != 0 || y_b != 0) wrap_bad++;
            end
            if (y_b != py && px != 10'd14) ybad++;
            prev_tick = tick_b; px = x_b; py = y_b;
        end
        chk("tick_count", ticks, 3);
        chk("tick_first_time", tick_t[1], 53);
        chk("tick_period_1", tick_t[2] - tick_t[1], 135);
        chk("tick_period_2", tick_t[3] - tick_t[2], 135);
        chk("tick_x", tick_x[1], 8);
        chk("tick_y", tick_y[1], 3);
        chk("frame_count_1", tick_fc[1], 1);
        chk("frame_count_2", tick_fc[2], 2);
        chk("frame_count_3", tick_fc[3], 3);
        chk("tick_width", wide, 0);
        chk("vs_low_3frames", vs_low, 90);
        chk("vs_first", vs_first, 76);
        chk("visible_high_3frames", g_high, 96);
        chk("blank_colour_b", viol, 0);
        chk("frame_wraps", wraps, 3);
        chk("wrap_to_origin", wrap_bad, 0);
        chk("y_only_on_h_wrap", ybad, 0);

        force dut_s.count_q = 16'hFFFF;
        step();
        chk("forced_count", fc_b, 65535);
        release dut_s.count_q;
        got = 0;
        for (int i = 0; i < 200 && got == 0; i++) begin
            step();
            if (tick_b) got = 1;
        end
        chk("wrap_tick_seen", got, 1);
        chk("frame_count_wrap", fc_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
